// File: rtl/core_pll_pkg.sv
// Shared types and defaults for the core PLL reset/lock sequencer.
package core_pll_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 74250;  // 1 ms at 74.25 MHz
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_SYNC_STAGES    = 2;

  // Width of the shared phase counter: enough for the longest phase.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous reset to 0.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // shift the asynchronous level through the flop chain
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Core PLL reset/lock sequencer: pulses pll_rst, waits for a qualified
// lock, then releases core_reset. Retries on timeout/glitch, faults after
// MAX_RETRIES, and re-runs the sequence on lock loss or reconfig request.
module pll_lock_sequencer
  import core_pll_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               req_reconfig,
  output logic                               pll_rst,
  output logic                               core_reset,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES+1);

  localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  pll_state_e    state, nxt_state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] nxt_retry;
  logic          lk;
  logic          lost_evt;
  logic          fail;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lk_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // state, shared phase counter, retry count and registered lock-lost pulse
  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= PLLRST;
      cnt         <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= nxt_state;
      retry_count <= nxt_retry;
      lock_lost   <= lost_evt;
      // restart timing on every phase change; saturate in long-lived phases
      if (nxt_state != state)  cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
    end
  end

  // next-state: phase timing, lock qualification and retry accounting
  always_comb begin
    nxt_state = state;
    nxt_retry = retry_count;
    lost_evt  = 1'b0;
    fail      = 1'b0;
    case (state)
      PLLRST:    if (cnt == RST_LAST) nxt_state = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lk)                  nxt_state = STABLE;
        else if (cnt == TO_LAST) fail = 1'b1;
      end
      STABLE: begin
        // any drop while qualifying counts as a failed attempt
        if (!lk) fail = 1'b1;
        else if (cnt == STB_LAST) begin
          nxt_state = RUN;
          nxt_retry = '0;
        end
      end
      RUN: begin
        // lock loss wins over a simultaneous reconfig request
        if (!lk) begin
          lost_evt  = 1'b1;
          nxt_state = PLLRST;
          nxt_retry = '0;
        end else if (req_reconfig) begin
          nxt_state = PLLRST;
          nxt_retry = '0;
        end
      end
      FAULT: begin
        if (req_reconfig) begin
          nxt_state = PLLRST;
          nxt_retry = '0;
        end
      end
      default: nxt_state = PLLRST;
    endcase
    if (fail) begin
      if (retry_count < RETRY_MAX) begin
        nxt_retry = retry_count + 1'b1;
        nxt_state = PLLRST;
      end else begin
        nxt_state = FAULT;
      end
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    pll_rst    = (state == PLLRST);
    core_reset = (state != RUN);
    ready      = (state == RUN);
    fault      = (state == FAULT);
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase-level reference model
// predicts every cycle's outputs, a monitor compares them, and timestamped
// milestone checks pin the absolute timings of the nominal scenarios.
module tb_pll_lock_sequencer;

  localparam int PR = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam int SS = 2;
  localparam int RW = $clog2(MR+1);

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          req_reconfig = 1'b0;
  logic          pll_rst, core_reset, ready, fault, lock_lost;
  logic [RW-1:0] retry_count;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
    .MAX_RETRIES(MR), .SYNC_STAGES(SS)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .req_reconfig(req_reconfig), .pll_rst(pll_rst), .core_reset(core_reset),
    .ready(ready), .fault(fault), .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    bit pll_rst, core_reset, ready, fault, lock_lost;
    int retry;
  } obs_t;

  typedef struct {
    string nm;
    int    got;
    int    exp;
  } dir_t;

  obs_t exp_q[$];
  dir_t dir_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- reference model ----------------
  // Phase name, cycles spent in it, attempts failed so far, and the
  // pll_locked history seen through the synchronizer delay.
  string m_phase = "PLLRST";
  int    m_age = 0;
  int    m_tries = 0;
  bit    m_lost = 1'b0;
  bit    m_line[$];

  task automatic model_step(input bit r, input bit l, input bit q);
    bit    lk;
    bit    fail;
    string nxt;
    obs_t  o;
    if (r) begin
      m_phase = "PLLRST"; m_age = 0; m_tries = 0; m_lost = 1'b0;
      m_line.delete();
      repeat (SS) m_line.push_back(1'b0);
    end else begin
      lk = m_line.pop_front();
      m_line.push_back(l);
      nxt = m_phase; fail = 1'b0; m_lost = 1'b0;
      if (m_phase == "PLLRST") begin
        if (m_age == PR-1) nxt = "WAIT";
      end else if (m_phase == "WAIT") begin
        if (lk) nxt = "STABLE";
        else if (m_age == TO-1) fail = 1'b1;
      end else if (m_phase == "STABLE") begin
        if (!lk) fail = 1'b1;
        else if (m_age == ST-1) begin nxt = "RUN"; m_tries = 0; end
      end else if (m_phase == "RUN") begin
        if (!lk) begin m_lost = 1'b1; nxt = "PLLRST"; m_tries = 0; end
        else if (q) begin nxt = "PLLRST"; m_tries = 0; end
      end else begin
        if (q) begin nxt = "PLLRST"; m_tries = 0; end
      end
      if (fail) begin
        if (m_tries < MR) begin m_tries++; nxt = "PLLRST"; end
        else nxt = "FAULT";
      end
      m_age   = (nxt == m_phase) ? m_age + 1 : 0;
      m_phase = nxt;
    end
    o.pll_rst    = (m_phase == "PLLRST");
    o.core_reset = (m_phase != "RUN");
    o.ready      = (m_phase == "RUN");
    o.fault      = (m_phase == "FAULT");
    o.lock_lost  = m_lost;
    o.retry      = m_tries;
    exp_q.push_back(o);
  endtask

  // ---------------- milestone log ----------------
  int cyc_no = 0;
  bit prev_rst = 1'b1;
  int ready_at, fault_at, lost_at, lost_cnt;
  int rise_q[$];
  bit last_pll_rst;

  task automatic clr_log();
    ready_at = -1; fault_at = -1; lost_at = -1; lost_cnt = 0;
    rise_q.delete(); last_pll_rst = 1'b0;
  endtask

  task automatic dir(input string nm, input int got, input int exp);
    dir_t d;
    d.nm = nm; d.got = got; d.exp = exp;
    dir_q.push_back(d);
  endtask

  // One cycle: note this cycle's outputs, drive its inputs, predict the next.
  task automatic cyc(input bit r, input bit l, input bit q);
    @(posedge refclk);
    #2;
    cyc_no = prev_rst ? 0 : cyc_no + 1;
    if (prev_rst) clr_log();
    if (!prev_rst) begin
      if (ready && ready_at < 0) ready_at = cyc_no;
      if (fault && fault_at < 0) fault_at = cyc_no;
      if (lock_lost) begin
        lost_cnt++;
        if (lost_at < 0) lost_at = cyc_no;
      end
      if (pll_rst && !last_pll_rst) rise_q.push_back(cyc_no);
      last_pll_rst = pll_rst;
    end
    prev_rst     = r;
    rst          = r;
    pll_locked   = l;
    req_reconfig = q;
    model_step(r, l, q);
  endtask

  // ---------------- monitor ----------------
  obs_t mon_e;
  dir_t mon_d;

  always @(posedge refclk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (pll_rst !== mon_e.pll_rst || core_reset !== mon_e.core_reset ||
          ready !== mon_e.ready || fault !== mon_e.fault ||
          lock_lost !== mon_e.lock_lost || int'(retry_count) != mon_e.retry) begin
        n_err++;
        $display("FAIL outputs t=%0t: got pll_rst=%b core_reset=%b ready=%b fault=%b lock_lost=%b retry=%0d, want %b %b %b %b %b %0d",
                 $time, pll_rst, core_reset, ready, fault, lock_lost, retry_count,
                 mon_e.pll_rst, mon_e.core_reset, mon_e.ready, mon_e.fault,
                 mon_e.lock_lost, mon_e.retry);
      end
    end
    while (dir_q.size() > 0) begin
      mon_d = dir_q.pop_front();
      n_vec++;
      if (mon_d.got != mon_d.exp) begin
        n_err++;
        $display("FAIL %s: got %0d want %0d", mon_d.nm, mon_d.got, mon_d.exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  int t0;
  int seg;
  bit lvl;

  initial begin
    clr_log();
    // reset state
    repeat (3) cyc(1'b1, 1'b0, 1'b0);

    // nominal lock: pll_locked rises at cycle 10
    for (int c = 0; c < 30; c++) cyc(1'b0, c >= 10, 1'b0);
    dir("nominal ready_at", ready_at, 10 + SS + 1 + ST);
    dir("nominal pll_rst pulses", rise_q.size(), 1);

    // lock loss in RUN at cycle T, then relock
    clr_log();
    t0 = cyc_no + 1;
    repeat (6)  cyc(1'b0, 1'b0, 1'b0);
    repeat (24) cyc(1'b0, 1'b1, 1'b0);
    dir("lock_lost at", lost_at - t0, SS + 1);
    dir("lock_lost pulses", lost_cnt, 1);
    dir("relock pll_rst rise", rise_q.size() > 0 ? rise_q[0] - t0 : -1, SS + 1);

    // reconfig in RUN
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);

    // never locks, then reconfig out of FAULT, then reconfig in WAIT_LOCK
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 80; c++) cyc(1'b0, 1'b0, 1'b0);
    dir("nolock fault_at", fault_at, 3 * (PR + TO));
    dir("nolock 2nd pll_rst", rise_q.size() > 1 ? rise_q[1] : -1, PR + TO);
    dir("nolock 3rd pll_rst", rise_q.size() > 2 ? rise_q[2] : -1, 2 * (PR + TO));
    cyc(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, k == 6);
    dir("fault recovery pll_rst count", rise_q.size(), 4);

    // glitch during STABLE: lock from 5, one low cycle at 11
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 40; c++) cyc(1'b0, (c >= 5) && (c != 11), 1'b0);
    dir("glitch ready_at", ready_at, 27);

    // mid-sequence reset at STABLE counter 5, then full re-run
    cyc(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) cyc(1'b0, c >= 2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) cyc(1'b0, c >= 10, 1'b0);
    dir("rerun ready_at", ready_at, 10 + SS + 1 + ST);

    // randomized segments of lock level, sparse reconfig and reset
    seg = 0; lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (seg == 0) begin
        lvl = ($urandom_range(0, 3) != 0);
        seg = lvl ? $urandom_range(1, 60) : $urandom_range(1, 30);
      end
      seg--;
      cyc($urandom_range(0, 399) == 0, lvl, $urandom_range(0, 11) == 0);
    end

    repeat (3) @(posedge refclk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Owns the reset and lock sequencing of the core PLL, i.e. the 74.25 MHz ref → 96/32/8/8(phase-shifted) MHz generator.
- Pulses the PLL reset and waits for `locked`, with a timeout and bounded retries.
- Requires lock to stay stable for a qualification window before releasing the core-domain reset.
- On lock loss, re-asserts core reset and re-runs the sequence.
- Runs entirely on the 74.25 MHz reference clock, outside the PLL output domains.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT, 74250: cycles allowed in WAIT_LOCK before an attempt fails (1 ms).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 3: extra attempts after the first before FAULT (total attempts = MAX_RETRIES+1).
- SYNC_STAGES, 2: flops in the `pll_locked` synchronizer (≥2).

Ports:
- refclk  in  1  74.25 MHz reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- req_reconfig  in  1  single-cycle request to re-lock (from RUN or FAULT).
- pll_rst  out  1  drives PLL rst.
- core_reset  out  1  active-high reset for core clock domains (consumers re-synchronize).
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts in the current sequence.

Behaviour:
- **Synchronizer.** `pll_locked` passes through SYNC_STAGES flops to give `lk`. A level present from cycle t is visible as `lk` at t+SYNC_STAGES. The synchronizer flops reset to 0.
- **Outputs.** All outputs are Moore-decoded from the registered state. Exception: `lock_lost` is a registered pulse.
- **Reset values.** On `rst`: state=PLLRST, counter=0, retry_count=0, pll_rst=1, core_reset=1, ready=0, fault=0, lock_lost=0. `rst` mid-sequence restarts from PLLRST regardless of state.
- **Counter.** One shared counter of width $clog2(max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)). It clears on every state change; otherwise it increments and never wraps inside a state.
- **State PLLRST.**
  - Outputs: pll_rst=1, core_reset=1.
  - At counter==PLL_RST_CYCLES-1 → WAIT_LOCK, so the state lasts exactly PLL_RST_CYCLES cycles.
- **State WAIT_LOCK.**
  - Outputs: pll_rst=0, core_reset=1.
  - If lk=1 → STABLE.
  - Else, at counter==LOCK_TIMEOUT-1 → FAIL rule.
- **State STABLE.**
  - Outputs: pll_rst=0, core_reset=1.
  - If lk=0 → FAIL rule (a glitch counts as a failed attempt).
  - Else, at counter==STABLE_CYCLES-1 → RUN with retry_count cleared to 0.
- **FAIL rule.** If retry_count<MAX_RETRIES: retry_count+1 → PLLRST. Otherwise → FAULT, with retry_count held at MAX_RETRIES.
- **State RUN.**
  - Outputs: core_reset=0, ready=1, pll_rst=0.
  - If lk=0: lock_lost=1 for the next cycle only, then → PLLRST with retry_count=0. core_reset rises on the same edge as the state change.
  - Else if req_reconfig: → PLLRST with retry_count=0; no lock_lost.
  - lk=0 takes priority over req_reconfig.
- **State FAULT.**
  - Outputs: pll_rst=0, core_reset=1, fault=1; sticky.
  - Exits only on `rst`, or on req_reconfig → PLLRST with retry_count=0.
- **req_reconfig elsewhere.** Ignored in PLLRST, WAIT_LOCK and STABLE.
- **Release latency.** From `pll_locked` rising in WAIT_LOCK to core_reset falling: SYNC_STAGES + 1 + STABLE_CYCLES cycles.

Decomposition:
- **Package `core_pll_pkg`.**
  - State enum: PLLRST, WAIT_LOCK, STABLE, RUN, FAULT.
  - Default parameter constants.
  - Counter-width function.
- **Sub-module `bit_sync`.** Parameterized SYNC_STAGES flop chain with synchronous reset. Reused by other cross-domain single-bit paths.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2. Cycle 0 is the first cycle after `rst` drops.
- **Nominal lock.** pll_locked rises at cycle 10 → pll_rst high in cycles 0-3, low from 4. core_reset falls and ready rises at cycle 21. retry_count=0 throughout.
- **Never locks.** pll_locked held 0 → pll_rst pulses at cycles 0, 24 and 48, each 4 cycles wide. retry_count reads 1 from cycle 24 and 2 from cycle 48. fault=1 from cycle 72 and stays set; core_reset stays 1.
- **Lock loss in RUN.** After ready, drop pll_locked at cycle T → lock_lost is a single pulse at T+3. core_reset=1 and ready=0 from T+3; pll_rst high T+3..T+6. Re-raising pll_locked returns to RUN with retry_count=0.
- **Glitch during STABLE.** One-cycle low on pll_locked while in STABLE → return to PLLRST with retry_count=1. On the next successful qualification, RUN is entered and retry_count=0.
- **Reconfig and fault recovery.** req_reconfig in RUN → PLLRST next cycle; lock_lost stays 0. req_reconfig in FAULT → fault clears, pll_rst pulses 4 cycles, retry_count=0. req_reconfig in WAIT_LOCK has no effect.
- **Mid-sequence reset.** Assert rst during STABLE at counter=5 → next cycle: state PLLRST, counter=0, all outputs at their reset values. The full sequence re-runs from cycle 0.
